// File: rtl/axis_matvec_arbiter.sv
// Purpose: shares one in-order, fixed-latency matvec engine among N AXI-Stream requesters, routing each y result back to the requester that issued it.
// Latency: zero added cycles; request and return paths are combinational through the arbiter.
// Backpressure: issue stalls while the tag FIFO holds DEPTH ops; a stalled grant is locked until accepted; a result waits on its owner's m_tready.
module axis_matvec_arbiter #(
   parameter int N     = 4,
   parameter int W_KX  = 576,
   parameter int W_Y   = 152,
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [N-1:0]                 s_tvalid,
   output logic [N-1:0]                 s_tready,
   input  logic [N*W_KX-1:0]            s_tdata,
   output logic                         e_kx_tvalid,
   input  logic                         e_kx_tready,
   output logic [W_KX-1:0]              e_kx_tdata,
   input  logic                         e_y_tvalid,
   output logic                         e_y_tready,
   input  logic [W_Y-1:0]               e_y_tdata,
   output logic [N-1:0]                 m_tvalid,
   input  logic [N-1:0]                 m_tready,
   output logic [W_Y-1:0]               m_tdata,
   output logic [$clog2(DEPTH+1)-1:0]   outstanding,
   output logic                         err
);

   localparam int IW = $clog2(N);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [IW-1:0] ptr;
   logic [IW-1:0] lock_id;
   logic          lock;
   logic [IW-1:0] arb_id;
   logic [IW-1:0] scan_id;
   logic [IW-1:0] gid;
   logic [IW-1:0] h;
   logic [IW-1:0] tag_mem [DEPTH];
   logic [AW-1:0] rd;
   logic [AW-1:0] wr;
   logic [CW-1:0] count;
   logic          full;
   logic          nonempty;
   logic          push;
   logic          pop;

   // round-robin pick: first valid requester at or after ptr; scanning downward leaves the nearest one
   always_comb begin
      arb_id  = ptr;
      scan_id = '0;
      for (int k = N-1; k >= 0; k--) begin
         scan_id = IW'((int'(ptr) + k) % N);
         if (s_tvalid[scan_id]) arb_id = scan_id;
      end
   end

   assign gid         = lock ? lock_id : arb_id;
   assign full        = (count == CW'(DEPTH));
   assign nonempty    = (count != '0);
   assign e_kx_tvalid = !full && (lock || (s_tvalid != '0));
   assign e_kx_tdata  = s_tdata[gid*W_KX +: W_KX];
   assign push        = e_kx_tvalid && e_kx_tready;

   assign h           = tag_mem[rd];
   assign m_tdata     = e_y_tdata;
   assign e_y_tready  = nonempty && m_tready[h];
   assign pop         = e_y_tvalid && e_y_tready;
   assign outstanding = count;

   // grant one-hot ready only in the cycle the engine accepts the word
   always_comb begin
      s_tready = '0;
      if (push) s_tready[gid] = 1'b1;
   end

   // steer the engine result to the requester whose tag is at the FIFO head
   always_comb begin
      m_tvalid = '0;
      if (e_y_tvalid && nonempty) m_tvalid[h] = 1'b1;
   end

   // arbitration state: advance past the winner on accept, freeze the grant while the engine stalls
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ptr     <= '0;
         lock    <= 1'b0;
         lock_id <= '0;
      end else if (push) begin
         ptr  <= (gid == IW'(N-1)) ? '0 : gid + 1'b1;
         lock <= 1'b0;
      end else if (e_kx_tvalid) begin
         lock    <= 1'b1;
         lock_id <= gid;
      end
   end

   // tag FIFO: record issuer on accept, retire on result handshake
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) tag_mem[i] <= '0;
      end else begin
         if (push) begin
            tag_mem[wr] <= gid;
            wr          <= (wr == AW'(DEPTH-1)) ? '0 : wr + 1'b1;
         end
         if (pop) rd <= (rd == AW'(DEPTH-1)) ? '0 : rd + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // sticky flag: engine produced a result nobody is waiting for
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                       err <= 1'b0;
      else if (e_y_tvalid && !nonempty) err <= 1'b1;
   end

endmodule

// File: tb/tb_axis_matvec_arbiter.sv
// Bench for axis_matvec_arbiter: requester drivers, a fixed-latency engine stub and a queue-based reference model.
// Latency: outputs are compared every cycle on the falling edge.
// Backpressure: the engine stub and result sinks stall on demand to exercise locking and FIFO-full behaviour.
module tb_axis_matvec_arbiter;
   localparam int N = 4, W_KX = 576, W_Y = 152, DEPTH = 8, LAT = 3, ECAP = 8;
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [W_Y-1:0] KEY = {19{8'hA5}};

   logic                clk, rstn;
   logic [N-1:0]        s_tvalid, s_tready;
   logic [N*W_KX-1:0]   s_tdata;
   logic                e_kx_tvalid, e_kx_tready;
   logic [W_KX-1:0]     e_kx_tdata;
   logic                e_y_tvalid, e_y_tready;
   logic [W_Y-1:0]      e_y_tdata;
   logic [N-1:0]        m_tvalid, m_tready;
   logic [W_Y-1:0]      m_tdata;
   logic [CW-1:0]       outstanding;
   logic                err;

   axis_matvec_arbiter #(.N(N), .W_KX(W_KX), .W_Y(W_Y), .DEPTH(DEPTH)) dut (
      .clk(clk), .rstn(rstn),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
      .e_kx_tvalid(e_kx_tvalid), .e_kx_tready(e_kx_tready), .e_kx_tdata(e_kx_tdata),
      .e_y_tvalid(e_y_tvalid), .e_y_tready(e_y_tready), .e_y_tdata(e_y_tdata),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
      .outstanding(outstanding), .err(err));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [W_Y-1:0] y; int age; } eng_t;

   int ncmp = 0, nerr = 0;
   // reference model: issue order as a queue of requester ids
   int  mptr, mlock_id;
   bit  mlock, merr;
   int  tagq[$];
   // engine stub and per-requester expected results
   eng_t eng_q[$];
   logic [W_Y-1:0] exp_q [N][$];
   int  seq[N], left[N], rx_cnt[N], rx_base[N];
   bit  always_on, rnd_mready, rnd_stall, kx_stall, inject;
   logic [N-1:0] mrdy_val;
   int  peak, obs_gid, prev;
   // handshakes sampled on the falling edge
   bit  m_kx_hs, m_park, m_y_hs, m_yerr, d_kx_hs, d_y_hs;
   int  m_gid;
   logic [N-1:0] req_hs;
   logic [W_Y-1:0] kx_word;

   task automatic chk(input string tag, input logic [W_KX-1:0] obs, input logic [W_KX-1:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W_KX-1:0] mk_word(input int id, input int s);
      logic [W_KX-1:0] w;
      for (int b = 0; b < W_KX/32; b++) w[b*32 +: 32] = $urandom;
      w[7:0]  = 8'(id);
      w[23:8] = 16'(s);
      return w;
   endfunction

   function automatic bit idle();
      bit r = 1'b1;
      for (int i = 0; i < N; i++)
         if (left[i] != 0 || s_tvalid[i] || exp_q[i].size() != 0) r = 1'b0;
      if (tagq.size() != 0 || eng_q.size() != 0) r = 1'b0;
      return r;
   endfunction

   task automatic apply_outputs();
      if (rnd_stall) kx_stall = ($urandom_range(0, 3) == 0);
      e_kx_tready = !kx_stall && (eng_q.size() < ECAP);
      e_y_tvalid  = inject || (eng_q.size() > 0 && eng_q[0].age >= LAT);
      e_y_tdata   = (eng_q.size() > 0) ? eng_q[0].y : '0;
      m_tready    = rnd_mready ? N'($urandom) : mrdy_val;
   endtask

   // falling edge: compare against the model, then sample handshakes
   task automatic monitor();
      int eg; bit found, evld, eyr;
      logic [N-1:0] es, emv;
      found = mlock; eg = mlock ? mlock_id : mptr;
      for (int k = 0; k < N; k++)
         if (!found && s_tvalid[(mptr + k) % N]) begin eg = (mptr + k) % N; found = 1'b1; end
      evld = (tagq.size() < DEPTH) && (mlock || s_tvalid != '0);
      es = '0; if (evld && e_kx_tready) es[eg] = 1'b1;
      emv = '0; if (e_y_tvalid && tagq.size() > 0) emv[tagq[0]] = 1'b1;
      eyr = (tagq.size() > 0) && m_tready[tagq[0]];
      chk("e_kx_tvalid", e_kx_tvalid, evld);
      chk("s_tready", s_tready, es);
      if (evld) chk("e_kx_tdata", e_kx_tdata, s_tdata[eg*W_KX +: W_KX]);
      chk("m_tvalid", m_tvalid, emv);
      chk("e_y_tready", e_y_tready, eyr);
      chk("outstanding", outstanding, tagq.size());
      chk("err", err, merr);
      for (int i = 0; i < N; i++) begin
         if (m_tvalid[i] && m_tready[i]) begin
            chk("result_expected", exp_q[i].size() != 0, 1'b1);
            if (exp_q[i].size() != 0) chk("result_data", m_tdata, exp_q[i].pop_front());
            rx_cnt[i]++;
         end
      end
      if (int'(outstanding) > peak) peak = int'(outstanding);
      m_gid = eg; m_kx_hs = evld && e_kx_tready; m_park = evld && !e_kx_tready;
      m_y_hs = e_y_tvalid && eyr; m_yerr = e_y_tvalid && tagq.size() == 0;
      d_kx_hs = e_kx_tvalid && e_kx_tready; d_y_hs = e_y_tvalid && e_y_tready;
      kx_word = e_kx_tdata[W_Y-1:0];
      req_hs = s_tvalid & s_tready;
      obs_gid = -1;
      for (int i = 0; i < N; i++) if (s_tready[i]) obs_gid = i;
   endtask

   // just after the rising edge: advance model, engine stub and requesters
   task automatic drive();
      if (m_kx_hs) begin tagq.push_back(m_gid); mptr = (m_gid + 1) % N; mlock = 1'b0; end
      else if (m_park) begin mlock = 1'b1; mlock_id = m_gid; end
      if (m_y_hs) void'(tagq.pop_front());
      if (m_yerr) merr = 1'b1;
      if (d_y_hs && eng_q.size() > 0) void'(eng_q.pop_front());
      foreach (eng_q[j]) eng_q[j].age++;
      if (d_kx_hs) eng_q.push_back('{y: kx_word ^ KEY, age: 0});
      for (int i = 0; i < N; i++) begin
         if (req_hs[i]) begin
            exp_q[i].push_back(s_tdata[i*W_KX +: W_Y] ^ KEY);
            s_tvalid[i] = 1'b0; seq[i]++; left[i]--;
         end
         if (!s_tvalid[i] && left[i] > 0 && (always_on || $urandom_range(0, 1) == 1)) begin
            s_tvalid[i] = 1'b1;
            s_tdata[i*W_KX +: W_KX] = mk_word(i, seq[i]);
         end
      end
      apply_outputs();
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic wait_drain(input string tag, input int max);
      for (int c = 0; c < max && !idle(); c++) step();
      chk(tag, idle(), 1'b1);
   endtask

   task automatic clear_all();
      mptr = 0; mlock = 1'b0; mlock_id = 0; merr = 1'b0;
      tagq.delete(); eng_q.delete();
      for (int i = 0; i < N; i++) begin exp_q[i].delete(); left[i] = 0; end
      s_tvalid = '0; inject = 1'b0; kx_stall = 1'b0;
      m_kx_hs = 0; m_park = 0; m_y_hs = 0; m_yerr = 0; d_kx_hs = 0; d_y_hs = 0; req_hs = '0;
      apply_outputs();
   endtask

   task automatic snap();
      for (int i = 0; i < N; i++) rx_base[i] = rx_cnt[i];
   endtask

   initial begin
      rstn = 1'b0; s_tdata = '0; always_on = 1'b1; rnd_mready = 1'b0; rnd_stall = 1'b0;
      mrdy_val = '1; kx_word = '0;
      for (int i = 0; i < N; i++) begin seq[i] = 0; rx_cnt[i] = 0; end
      clear_all();
      step(); step();
      chk("rst_e_kx_tvalid", e_kx_tvalid, 1'b0);
      chk("rst_m_tvalid", m_tvalid, '0);
      chk("rst_e_y_tready", e_y_tready, 1'b0);
      chk("rst_outstanding", outstanding, '0);
      chk("rst_err", err, 1'b0);
      rstn = 1'b1;

      // single requester streams 5 words with everything ready
      snap(); peak = 0; left[2] = 5;
      wait_drain("t1_drain", 100);
      chk("t1_count", rx_cnt[2] - rx_base[2], 5);
      chk("t1_others", rx_cnt[0] + rx_cnt[1] + rx_cnt[3] - rx_base[0] - rx_base[1] - rx_base[3], 0);
      chk("t1_peak_bound", peak <= LAT + 1, 1'b1);

      // all requesters valid continuously: grants rotate by one each cycle
      snap(); prev = -1;
      for (int i = 0; i < N; i++) left[i] = 6;
      for (int c = 0; c < 30; c++) begin
         step();
         if (obs_gid >= 0) begin
            if (prev >= 0) chk("t2_rotate", obs_gid, (prev + 1) % N);
            prev = obs_gid;
         end
      end
      wait_drain("t2_drain", 100);
      for (int i = 0; i < N; i++) chk("t2_per_port", rx_cnt[i] - rx_base[i], 6);

      // lock: requester 1 granted under engine stall, requester 0 (favoured by ptr) arrives later
      left[3] = 1;
      wait_drain("t3_pre", 50);
      snap(); kx_stall = 1'b1; left[1] = 1;
      step();
      left[0] = 1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("t3_hold_id", e_kx_tdata[7:0], 8'd1);
         chk("t3_hold_valid", e_kx_tvalid, 1'b1);
      end
      kx_stall = 1'b0;
      wait_drain("t3_drain", 50);
      chk("t3_req1", rx_cnt[1] - rx_base[1], 1);
      chk("t3_req0", rx_cnt[0] - rx_base[0], 1);

      // result sink stalled: FIFO fills to DEPTH and issue stops
      snap(); mrdy_val = '0;
      for (int i = 0; i < N; i++) left[i] = 5;
      for (int c = 0; c < 20; c++) step();
      chk("t4_full", outstanding, DEPTH);
      chk("t4_no_issue", e_kx_tvalid, 1'b0);
      mrdy_val = '1;
      wait_drain("t4_drain", 200);
      for (int i = 0; i < N; i++) chk("t4_per_port", rx_cnt[i] - rx_base[i], 5);

      // stray engine result with nothing outstanding
      inject = 1'b1;
      step(); step();
      chk("t5_err", err, 1'b1);
      chk("t5_y_tready", e_y_tready, 1'b0);
      chk("t5_m_tvalid", m_tvalid, '0);
      inject = 1'b0;
      step(); step();
      chk("t5_sticky", err, 1'b1);

      // reset with ops in flight, then fresh traffic
      mrdy_val = '0; left[0] = 3;
      for (int c = 0; c < 30 && outstanding != 3; c++) step();
      chk("t6_inflight", outstanding, 3);
      rstn = 1'b0; clear_all();
      step();
      chk("t6_rst_outstanding", outstanding, '0);
      chk("t6_rst_err", err, 1'b0);
      chk("t6_rst_kx_vld", e_kx_tvalid, 1'b0);
      chk("t6_rst_m_tvalid", m_tvalid, '0);
      chk("t6_rst_s_tready", s_tready, '0);
      rstn = 1'b1; mrdy_val = '1;
      snap(); left[1] = 4; left[2] = 4;
      step();
      wait_drain("t6_drain", 100);
      chk("t6_req1", rx_cnt[1] - rx_base[1], 4);
      chk("t6_req2", rx_cnt[2] - rx_base[2], 4);

      // random valids, sink readiness and engine stalls
      snap(); always_on = 1'b0; rnd_mready = 1'b1; rnd_stall = 1'b1;
      for (int i = 0; i < N; i++) left[i] = $urandom_range(20, 40);
      for (int c = 0; c < 300; c++) step();
      rnd_mready = 1'b0; rnd_stall = 1'b0; kx_stall = 1'b0; mrdy_val = '1;
      wait_drain("t7_drain", 600);
      chk("t7_no_err", err, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
